// File: rtl/fetch_sequencer_if.sv
// Instruction-memory read bus between the fetch sequencer (master) and memory (slave).
// A read completes on the clock edge where mem_req and mem_ack are both high.
interface fetch_sequencer_if;
   logic        mem_req;
   logic [15:0] mem_addr;
   logic        mem_ack;
   logic [15:0] mem_rdata;

   modport master (output mem_req, output mem_addr, input mem_ack, input mem_rdata);
   modport slave  (input mem_req, input mem_addr, output mem_ack, output mem_rdata);
endinterface

// File: rtl/fetch_sequencer.sv
// Handshaked instruction-fetch sequencer: fetches opcode + 0..2 extension words, issues, waits for execute.
// Optional ack timeout with sticky error state is enabled by defining FETCH_SEQ_TIMEOUT_EN.
module fetch_sequencer #(
   parameter logic [15:0] RESET_PC    = 16'h0000,
   parameter int          ACK_TIMEOUT = 15
) (
   input  logic                      clk,
   input  logic                      rst,
   fetch_sequencer_if.master         mem,
   output logic                      ins_valid,
   input  logic                      dec_ready,
   output logic [15:0]               instruction,
   output logic [15:0]               instruction_1,
   output logic [15:0]               instruction_2,
   output logic [1:0]                ext_count,
   output logic [15:0]               pc,
   input  logic                      exec_done,
   input  logic                      branch_taken,
   output logic [2:0]                fsm_state,
   output logic                      fetch_err
);

   typedef enum logic [2:0] {
      S_IDLE  = 3'd0,
      S_F0    = 3'd1,
      S_F1    = 3'd2,
      S_F2    = 3'd3,
      S_ISSUE = 3'd4,
      S_EXEC  = 3'd5,
      S_ERR   = 3'd6
   } state_t;

   localparam logic [15:0] START_PC = {RESET_PC[15:1], 1'b0};

   state_t      state_q, state_d;
   logic [15:0] ptr_q, ptr_d;
   logic [15:0] pc_q, pc_d;
   logic [15:0] ins0_q, ins0_d;
   logic [15:0] ins1_q, ins1_d;
   logic [15:0] ins2_q, ins2_d;
   logic [1:0]  n_q, n_d;
   logic        is_fetch;

   // Extension words: source immediate/indexed plus indexed destination for double-operand ops.
   function automatic logic [1:0] ext_words(input logic [15:0] op);
      logic src_ext;
      logic dst_ext;
      src_ext = 1'b0;
      dst_ext = 1'b0;
      if (op[15:12] >= 4'h4) begin
         src_ext = (op[5:4] == 2'b01) || ((op[5:4] == 2'b11) && (op[11:8] == 4'h0));
         dst_ext = op[7];
      end else if (op[15:12] == 4'h1) begin
         src_ext = (op[5:4] == 2'b01) || ((op[5:4] == 2'b11) && (op[3:0] == 4'h0));
      end
      return {1'b0, src_ext} + {1'b0, dst_ext};
   endfunction

   assign is_fetch = (state_q == S_F0) || (state_q == S_F1) || (state_q == S_F2);

`ifdef FETCH_SEQ_TIMEOUT_EN
   logic [7:0] wait_q, wait_d;
`endif

   always_comb begin
      state_d = state_q;
      ptr_d   = ptr_q;
      pc_d    = pc_q;
      ins0_d  = ins0_q;
      ins1_d  = ins1_q;
      ins2_d  = ins2_q;
      n_d     = n_q;
      case (state_q)
         S_IDLE: state_d = S_F0;
         S_F0: begin
            if (mem.mem_ack) begin
               ins0_d  = mem.mem_rdata;
               ins1_d  = 16'h0000;
               ins2_d  = 16'h0000;
               pc_d    = ptr_q;
               n_d     = ext_words(mem.mem_rdata);
               ptr_d   = ptr_q + 16'd2;
               state_d = (ext_words(mem.mem_rdata) == 2'd0) ? S_ISSUE : S_F1;
            end
         end
         S_F1: begin
            if (mem.mem_ack) begin
               ins1_d  = mem.mem_rdata;
               ptr_d   = ptr_q + 16'd2;
               state_d = (n_q == 2'd2) ? S_F2 : S_ISSUE;
            end
         end
         S_F2: begin
            if (mem.mem_ack) begin
               ins2_d  = mem.mem_rdata;
               ptr_d   = ptr_q + 16'd2;
               state_d = S_ISSUE;
            end
         end
         S_ISSUE: begin
            if (dec_ready) state_d = S_EXEC;
         end
         S_EXEC: begin
            if (exec_done) begin
               state_d = S_F0;
               // Jump opcodes 2 and 3: word offset in [9:0], relative to the next word.
               if (branch_taken && (ins0_q[15:13] == 3'b001))
                  ptr_d = pc_q + 16'd2 + {{5{ins0_q[9]}}, ins0_q[9:0], 1'b0};
            end
         end
         S_ERR:   state_d = S_ERR;
         default: state_d = S_IDLE;
      endcase

`ifdef FETCH_SEQ_TIMEOUT_EN
      wait_d = wait_q;
      if (is_fetch) begin
         if (mem.mem_ack) begin
            wait_d = 8'd0;
         end else if (wait_q == 8'(ACK_TIMEOUT - 1)) begin
            wait_d  = 8'd0;
            state_d = S_ERR;
         end else begin
            wait_d = wait_q + 8'd1;
         end
      end
`endif
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q <= S_IDLE;
         ptr_q   <= START_PC;
         pc_q    <= 16'h0000;
         ins0_q  <= 16'h0000;
         ins1_q  <= 16'h0000;
         ins2_q  <= 16'h0000;
         n_q     <= 2'd0;
      end else begin
         state_q <= state_d;
         ptr_q   <= ptr_d;
         pc_q    <= pc_d;
         ins0_q  <= ins0_d;
         ins1_q  <= ins1_d;
         ins2_q  <= ins2_d;
         n_q     <= n_d;
      end
   end

`ifdef FETCH_SEQ_TIMEOUT_EN
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) wait_q <= 8'd0;
      else      wait_q <= wait_d;
   end
   assign fetch_err = (state_q == S_ERR);
`else
   // Without the timeout the error flag is constant low; the comparison only keeps ACK_TIMEOUT referenced.
   assign fetch_err = 1'b0 & (ACK_TIMEOUT == 0);
`endif

   assign mem.mem_req    = is_fetch;
   assign mem.mem_addr   = ptr_q;
   assign ins_valid      = (state_q == S_ISSUE);
   assign instruction    = ins0_q;
   assign instruction_1  = ins1_q;
   assign instruction_2  = ins2_q;
   assign ext_count      = n_q;
   assign pc             = pc_q;
   assign fsm_state      = state_q;

endmodule

// File: tb/tb_fetch_sequencer.sv
// Directed bench for fetch_sequencer: memory reads, issue handshake, branch targets, reset abort, timeout.
module tb_fetch_sequencer;
  logic        clk;
  logic        rst;
  logic        ins_valid;
  logic        dec_ready;
  logic [15:0] instruction;
  logic [15:0] instruction_1;
  logic [15:0] instruction_2;
  logic [1:0]  ext_count;
  logic [15:0] pc;
  logic        exec_done;
  logic        branch_taken;
  logic [2:0]  fsm_state;
  logic        fetch_err;
  int          n_cmp;
  int          n_fail;

  fetch_sequencer_if mem_bus ();

  fetch_sequencer #(.RESET_PC(16'h0000), .ACK_TIMEOUT(15)) dut (
    .clk           (clk),
    .rst           (rst),
    .mem           (mem_bus.master),
    .ins_valid     (ins_valid),
    .dec_ready     (dec_ready),
    .instruction   (instruction),
    .instruction_1 (instruction_1),
    .instruction_2 (instruction_2),
    .ext_count     (ext_count),
    .pc            (pc),
    .exec_done     (exec_done),
    .branch_taken  (branch_taken),
    .fsm_state     (fsm_state),
    .fetch_err     (fetch_err)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Memory driver: wait for the request, hold it for `waits` cycles, then return `data`.
  task automatic serve(input logic [15:0] addr, input logic [15:0] data, input int waits);
    int i;
    i = 0;
    while (!mem_bus.mem_req && i < 20) begin
      @(negedge clk);
      i++;
    end
    check("mem_req_seen", {15'd0, mem_bus.mem_req}, 16'd1);
    check("mem_addr", mem_bus.mem_addr, addr);
    for (int w = 0; w < waits; w++) begin
      @(negedge clk);
      check("mem_req_hold", {15'd0, mem_bus.mem_req}, 16'd1);
      check("mem_addr_hold", mem_bus.mem_addr, addr);
    end
    mem_bus.mem_ack   = 1'b1;
    mem_bus.mem_rdata = data;
    @(negedge clk);
    mem_bus.mem_ack   = 1'b0;
    mem_bus.mem_rdata = 16'h0000;
  endtask

  task automatic expect_issue(input logic [15:0] i0, input logic [15:0] i1, input logic [15:0] i2,
                              input logic [1:0] n, input logic [15:0] exp_pc);
    int i;
    i = 0;
    while (!ins_valid && i < 20) begin
      @(negedge clk);
      i++;
    end
    check("ins_valid", {15'd0, ins_valid}, 16'd1);
    check("mem_req_in_issue", {15'd0, mem_bus.mem_req}, 16'd0);
    check("instruction", instruction, i0);
    check("instruction_1", instruction_1, i1);
    check("instruction_2", instruction_2, i2);
    check("ext_count", {14'd0, ext_count}, {14'd0, n});
    check("pc", pc, exp_pc);
    dec_ready = 1'b1;
    @(negedge clk);
    dec_ready = 1'b0;
    check("state_exec", {13'd0, fsm_state}, 16'd5);
    check("ins_valid_drop", {15'd0, ins_valid}, 16'd0);
  endtask

  task automatic do_exec(input logic bt);
    @(negedge clk);
    check("still_exec", {13'd0, fsm_state}, 16'd5);
    exec_done    = 1'b1;
    branch_taken = bt;
    @(negedge clk);
    exec_done    = 1'b0;
    branch_taken = 1'b0;
    check("state_f0", {13'd0, fsm_state}, 16'd1);
  endtask

  initial begin
    n_cmp = 0;
    n_fail = 0;
    rst = 1'b0;
    dec_ready = 1'b0;
    exec_done = 1'b0;
    branch_taken = 1'b0;
    mem_bus.mem_ack = 1'b0;
    mem_bus.mem_rdata = 16'h0000;
    repeat (3) @(negedge clk);

    // reset state
    check("rst_mem_req", {15'd0, mem_bus.mem_req}, 16'd0);
    check("rst_mem_addr", mem_bus.mem_addr, 16'h0000);
    check("rst_ins_valid", {15'd0, ins_valid}, 16'd0);
    check("rst_state", {13'd0, fsm_state}, 16'd0);
    check("rst_pc", pc, 16'h0000);
    check("rst_fetch_err", {15'd0, fetch_err}, 16'd0);
    rst = 1'b1;
    @(negedge clk);
    check("first_f0", {13'd0, fsm_state}, 16'd1);

    // no extension words; exec_done during ISSUE must be ignored
    serve(16'h0000, 16'h4504, 0);
    check("issue_state", {13'd0, fsm_state}, 16'd4);
    exec_done = 1'b1;
    @(negedge clk);
    exec_done = 1'b0;
    check("exec_done_ignored", {13'd0, fsm_state}, 16'd4);
    expect_issue(16'h4504, 16'h0000, 16'h0000, 2'd0, 16'h0000);
    do_exec(1'b0);

    // one indexed-source extension word
    serve(16'h0002, 16'h4514, 0);
    serve(16'h0004, 16'h0010, 0);
    expect_issue(16'h4514, 16'h0010, 16'h0000, 2'd1, 16'h0002);
    do_exec(1'b0);

    // two extension words, then immediate source
    serve(16'h0006, 16'h4594, 0);
    serve(16'h0008, 16'h1111, 0);
    serve(16'h000A, 16'h2222, 0);
    expect_issue(16'h4594, 16'h1111, 16'h2222, 2'd2, 16'h0006);
    do_exec(1'b0);
    serve(16'h000C, 16'h4034, 0);
    serve(16'h000E, 16'h1234, 0);
    expect_issue(16'h4034, 16'h1234, 16'h0000, 2'd1, 16'h000C);
    do_exec(1'b0);

    // jumps: forward, backward, self, not-taken, non-jump with branch_taken, opcode 2
    serve(16'h0010, 16'h3C05, 0);
    expect_issue(16'h3C05, 16'h0000, 16'h0000, 2'd0, 16'h0010);
    do_exec(1'b1);
    serve(16'h001C, 16'h3FF9, 0);
    expect_issue(16'h3FF9, 16'h0000, 16'h0000, 2'd0, 16'h001C);
    do_exec(1'b1);
    serve(16'h0010, 16'h3FFF, 0);
    expect_issue(16'h3FFF, 16'h0000, 16'h0000, 2'd0, 16'h0010);
    do_exec(1'b1);
    serve(16'h0010, 16'h3FFF, 0);
    expect_issue(16'h3FFF, 16'h0000, 16'h0000, 2'd0, 16'h0010);
    do_exec(1'b0);
    serve(16'h0012, 16'h4504, 0);
    expect_issue(16'h4504, 16'h0000, 16'h0000, 2'd0, 16'h0012);
    do_exec(1'b1);
    serve(16'h0014, 16'h2003, 0);
    expect_issue(16'h2003, 16'h0000, 16'h0000, 2'd0, 16'h0014);
    do_exec(1'b1);

    // wait states, then reset during F1
    serve(16'h001C, 16'h1234, 3);
    expect_issue(16'h1234, 16'h0000, 16'h0000, 2'd0, 16'h001C);
    do_exec(1'b0);
    serve(16'h001E, 16'h4514, 0);
    check("in_f1", {13'd0, fsm_state}, 16'd2);
    rst = 1'b0;
    #1;
    check("arst_mem_req", {15'd0, mem_bus.mem_req}, 16'd0);
    check("arst_mem_addr", mem_bus.mem_addr, 16'h0000);
    check("arst_instruction", instruction, 16'h0000);
    check("arst_pc", pc, 16'h0000);
    check("arst_state", {13'd0, fsm_state}, 16'd0);
    @(negedge clk);
    rst = 1'b1;
    serve(16'h0000, 16'h3FFE, 0);
    expect_issue(16'h3FFE, 16'h0000, 16'h0000, 2'd0, 16'h0000);
    do_exec(1'b1);

    // address wrap across 0xFFFE
    serve(16'hFFFE, 16'h4514, 0);
    serve(16'h0000, 16'h0010, 0);
    expect_issue(16'h4514, 16'h0010, 16'h0000, 2'd1, 16'hFFFE);
    do_exec(1'b0);
    check("wrap_next_addr", mem_bus.mem_addr, 16'h0002);

    // ack never arrives
    repeat (14) @(negedge clk);
    check("pre_timeout_req", {15'd0, mem_bus.mem_req}, 16'd1);
    repeat (11) @(negedge clk);
`ifdef FETCH_SEQ_TIMEOUT_EN
    check("timeout_err", {15'd0, fetch_err}, 16'd1);
    check("timeout_req", {15'd0, mem_bus.mem_req}, 16'd0);
    check("timeout_state", {13'd0, fsm_state}, 16'd6);
    check("timeout_ins_valid", {15'd0, ins_valid}, 16'd0);
`else
    check("no_timeout_err", {15'd0, fetch_err}, 16'd0);
    check("no_timeout_req", {15'd0, mem_bus.mem_req}, 16'd1);
    check("no_timeout_state", {13'd0, fsm_state}, 16'd1);
    check("no_timeout_addr", mem_bus.mem_addr, 16'h0002);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
